lcd_nibble_decoder: RTL and testbench



---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_bus_sync.sv | 49 ++++
 rtl/lcd_nibble_decoder.sv | 189 ++++++++++++++++++
 tb/tb_lcd_nibble_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD bus definitions: decoder states, function-set nibbles and command opcodes.
// Also used by the LCD driver, so opcodes live here rather than in either block.
package lcd_pkg;

    typedef enum logic [1:0] {
        S_8BIT = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } lcd_state_e;

    // Bus lines other than enable, in the order they enter the synchronizer.
    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [3:0] nib;
    } lcd_bus_t;

    localparam logic [3:0] LCD_FUNCSET_4BIT = 4'h2;
    localparam logic [3:0] LCD_FUNCSET_8BIT = 4'h3;
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;

endpackage

// File: rtl/lcd_bus_sync.sv
// Shared synchronizer chain for enable plus data lines, with registered enable edge pulses.
// Edges appear SYNC_STAGES+1 cycles after the pin; e_o is aligned with the edge pulses.
module lcd_bus_sync #(
    parameter int W           = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         e_i,
    input  logic [W-1:0] dat_i,
    output logic         e_o,
    output logic [W-1:0] dat_o,
    output logic         rise_o,
    output logic         fall_o
);

    logic [W:0] sync_q [SYNC_STAGES];
    logic       e_prev_q;
    logic       rise_q;
    logic       fall_q;
    logic       e_cur;

    assign e_cur = sync_q[SYNC_STAGES-1][W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            e_prev_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q[0] <= {e_i, dat_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            e_prev_q <= e_cur;
            rise_q   <= e_cur & ~e_prev_q;
            fall_q   <= ~e_cur & e_prev_q;
        end
    end

    assign e_o    = e_prev_q;
    assign dat_o  = sync_q[SYNC_STAGES-1][W-1:0];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/lcd_nibble_decoder.sv
// Receive-side HD44780 4-bit bus decoder: tracks 8-bit/4-bit mode, rebuilds bytes, flags errors.
// Bytes and error pulses appear SYNC_STAGES+2 cycles after the lcd_e pin falls; no backpressure.
module lcd_nibble_decoder
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_E_CYC   = 12,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_4,
    input  logic       lcd_5,
    input  logic       lcd_6,
    input  logic       lcd_7,
    output logic [7:0] byte_out,
    output logic       byte_is_data,
    output logic       byte_valid,
    output logic       mode4,
    output logic       err_short,
    output logic       err_rs,
    output logic       err_timeout
);

    localparam int EW = $clog2(MIN_E_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);

    lcd_bus_t                bus_in;
    lcd_bus_t                bus;
    logic [$bits(lcd_bus_t)-1:0] bus_s;
    logic                    e_s;
    logic                    e_rise;
    logic                    e_fall;

    assign bus_in = {lcd_rs, lcd_rw, lcd_7, lcd_6, lcd_5, lcd_4};
    assign bus    = lcd_bus_t'(bus_s);

    lcd_bus_sync #(
        .W           ($bits(lcd_bus_t)),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .e_i    (lcd_e),
        .dat_i  (bus_in),
        .e_o    (e_s),
        .dat_o  (bus_s),
        .rise_o (e_rise),
        .fall_o (e_fall)
    );

    lcd_state_e  state_q, state_d;
    logic [EW-1:0] ecnt_q, ecnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]  hi_q, hi_d;
    logic        hrs_q, hrs_d;
    logic [7:0]  byte_q, byte_d;
    logic        isdata_q, isdata_d;
    logic        bv_q, bv_d;
    logic        mode4_q, mode4_d;
    logic        es_q, es_d;
    logic        ers_q, ers_d;
    logic        eto_q, eto_d;
    logic        e_long;
    logic        qual;

    assign e_long = (ecnt_q >= EW'(MIN_E_CYC));
    assign qual   = e_fall && e_long && !bus.rw;

    always_comb begin
        state_d  = state_q;
        ecnt_d   = ecnt_q;
        tcnt_d   = tcnt_q;
        hi_d     = hi_q;
        hrs_d    = hrs_q;
        byte_d   = byte_q;
        isdata_d = isdata_q;
        mode4_d  = mode4_q;
        bv_d     = 1'b0;
        es_d     = 1'b0;
        ers_d    = 1'b0;
        eto_d    = 1'b0;

        // The rise pulse lands on the first counted high cycle, hence restart at 1.
        if (e_rise) begin
            ecnt_d = EW'(1);
        end else if (e_s && !e_long) begin
            ecnt_d = ecnt_q + EW'(1);
        end

        if (e_fall && !e_long) begin
            es_d = 1'b1;
        end

        case (state_q)
            S_8BIT: begin
                if (qual) begin
                    bv_d     = 1'b1;
                    byte_d   = {bus.nib, 4'h0};
                    isdata_d = bus.rs;
                    if (!bus.rs && bus.nib == LCD_FUNCSET_4BIT) begin
                        state_d = S_HI;
                        mode4_d = 1'b1;
                    end
                end
            end
            S_HI: begin
                if (qual) begin
                    hi_d    = bus.nib;
                    hrs_d   = bus.rs;
                    tcnt_d  = '0;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (qual) begin
                    tcnt_d = '0;
                    if (bus.rs == hrs_q) begin
                        bv_d     = 1'b1;
                        byte_d   = {hi_q, bus.nib};
                        isdata_d = bus.rs;
                        if (!bus.rs && hi_q == LCD_FUNCSET_8BIT) begin
                            state_d = S_8BIT;
                            mode4_d = 1'b0;
                        end else begin
                            state_d = S_HI;
                        end
                    end else begin
                        // Mismatched rs restarts the byte with this nibble as its high half.
                        ers_d = 1'b1;
                        hi_d  = bus.nib;
                        hrs_d = bus.rs;
                    end
                end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    if (!e_fall) begin
                        eto_d   = 1'b1;
                        tcnt_d  = '0;
                        state_d = S_HI;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = S_8BIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_8BIT;
            ecnt_q   <= '0;
            tcnt_q   <= '0;
            hi_q     <= '0;
            hrs_q    <= 1'b0;
            byte_q   <= '0;
            isdata_q <= 1'b0;
            bv_q     <= 1'b0;
            mode4_q  <= 1'b0;
            es_q     <= 1'b0;
            ers_q    <= 1'b0;
            eto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ecnt_q   <= ecnt_d;
            tcnt_q   <= tcnt_d;
            hi_q     <= hi_d;
            hrs_q    <= hrs_d;
            byte_q   <= byte_d;
            isdata_q <= isdata_d;
            bv_q     <= bv_d;
            mode4_q  <= mode4_d;
            es_q     <= es_d;
            ers_q    <= ers_d;
            eto_q    <= eto_d;
        end
    end

    assign byte_out     = byte_q;
    assign byte_is_data = isdata_q;
    assign byte_valid   = bv_q;
    assign mode4        = mode4_q;
    assign err_short    = es_q;
    assign err_rs       = ers_q;
    assign err_timeout  = eto_q;

endmodule

// File: tb/tb_lcd_nibble_decoder.sv
// Bench for lcd_nibble_decoder: event-level reference model predicts every output cycle,
// directed scenarios pin the model with literal bytes, then randomized pulse traffic.
module tb_lcd_nibble_decoder;
    import lcd_pkg::*;

    localparam int SYNC = 2;
    localparam int MINE = 12;
    localparam int TO   = 50000;
    localparam int LAT  = SYNC + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic       lcd_4 = 1'b0, lcd_5 = 1'b0, lcd_6 = 1'b0, lcd_7 = 1'b0;
    logic [7:0] byte_out;
    logic       byte_is_data, byte_valid, mode4, err_short, err_rs, err_timeout;

    lcd_nibble_decoder #(
        .SYNC_STAGES (SYNC),
        .MIN_E_CYC   (MINE),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_e        (lcd_e),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_4        (lcd_4),
        .lcd_5        (lcd_5),
        .lcd_6        (lcd_6),
        .lcd_7        (lcd_7),
        .byte_out     (byte_out),
        .byte_is_data (byte_is_data),
        .byte_valid   (byte_valid),
        .mode4        (mode4),
        .err_short    (err_short),
        .err_rs       (err_rs),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Expected output events: kind 0 = byte, 1 = short pulse, 2 = rs error.
    typedef struct {
        int         at;
        int         kind;
        logic [7:0] b;
        logic       d;
        logic       m4;
    } ev_t;

    ev_t evq[$];
    int  exp_to = -1;

    // Protocol-level model: 0 = 8-bit init, 1 = waiting for high nibble, 2 = waiting for low.
    int         mst = 0;
    logic [3:0] mhi = 4'h0;
    logic       mhrs = 1'b0;
    int         mhi_fall = 0;
    logic       mm4 = 1'b0;

    task automatic push(input int at, input int kind, input logic [7:0] b, input logic d);
        ev_t ev;
        ev.at = at; ev.kind = kind; ev.b = b; ev.d = d; ev.m4 = mm4;
        evq.push_back(ev);
    endtask

    task automatic model_pulse(input logic rs, input logic rw, input logic [3:0] nib,
                               input int w, input int d);
        if (mst == 2 && d - mhi_fall > TO) mst = 1;
        if (w < MINE) begin
            push(d + LAT, 1, 8'h00, 1'b0);
        end else if (!rw) begin
            if (mst == 0) begin
                if (!rs && nib == 4'h2) begin
                    mst = 1;
                    mm4 = 1'b1;
                end
                push(d + LAT, 0, {nib, 4'h0}, rs);
            end else if (mst == 1) begin
                mhi = nib; mhrs = rs; mhi_fall = d; mst = 2;
                exp_to = d + LAT + TO;
            end else begin
                exp_to = -1;
                if (rs == mhrs) begin
                    if (!rs && mhi == 4'h3) begin
                        mst = 0;
                        mm4 = 1'b0;
                    end else begin
                        mst = 1;
                    end
                    push(d + LAT, 0, {mhi, nib}, rs);
                end else begin
                    push(d + LAT, 2, 8'h00, 1'b0);
                    mhi = nib; mhrs = rs; mhi_fall = d;
                    exp_to = d + LAT + TO;
                end
            end
        end
    endtask

    // Compare process plus observation counters for the directed literal checks.
    logic       cm4 = 1'b0;
    logic       e_bv, e_es, e_ers, e_to, e_d;
    logic [7:0] e_b;
    ev_t        cur;
    int         n_bytes = 0, n_short = 0, n_rs = 0, n_to = 0, last_cyc = 0;
    logic [7:0] last_b = 8'h00;
    logic       last_d = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("reset_outputs",
                32'({byte_out, byte_is_data, byte_valid, mode4, err_short, err_rs, err_timeout}), 32'h0);
        end else begin
            e_bv = 1'b0; e_es = 1'b0; e_ers = 1'b0; e_to = 1'b0; e_b = 8'h00; e_d = 1'b0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
                cur = evq.pop_front();
                e_bv  = (cur.kind == 0);
                e_es  = (cur.kind == 1);
                e_ers = (cur.kind == 2);
                e_b   = cur.b;
                e_d   = cur.d;
                cm4   = cur.m4;
            end
            if (exp_to == cyc) begin
                e_to   = 1'b1;
                exp_to = -1;
            end
            chk("strobes_mode4", 32'({byte_valid, err_short, err_rs, err_timeout, mode4}),
                32'({e_bv, e_es, e_ers, e_to, cm4}));
            if (e_bv) chk("byte", 32'({byte_is_data, byte_out}), 32'({e_d, e_b}));
            if (byte_valid) begin
                n_bytes++; last_b = byte_out; last_d = byte_is_data; last_cyc = cyc;
            end
            if (err_short)   n_short++;
            if (err_rs)      n_rs++;
            if (err_timeout) n_to++;
        end
    end

    int last_fall = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic rs, input logic rw, input logic [3:0] nib, input int w);
        int d;
        d = cyc + 1 + w;
        model_pulse(rs, rw, nib, w, d);
        lcd_rs = rs;
        lcd_rw = rw;
        {lcd_7, lcd_6, lcd_5, lcd_4} = nib;
        step(1);
        lcd_e = 1'b1;
        step(w);
        lcd_e = 1'b0;
        last_fall = cyc;
        step(4);
    endtask

    task automatic send(input logic rs, input logic [3:0] nib);
        pulse(rs, 1'b0, nib, MINE + 2);
        step(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lcd_e = 1'b0;
        evq.delete();
        exp_to = -1; mst = 0; mm4 = 1'b0; cm4 = 1'b0;
        step(3);
        rst = 1'b0;
        step(2);
    endtask

    int nb, ns, nr, nt;

    initial begin
        step(3);
        chk("rst_mode4", 32'(mode4), 32'h0);
        chk("rst_byte", 32'(byte_out), 32'h0);
        rst = 1'b0;
        step(2);

        // Init: three 8-bit function sets then switch to 4-bit.
        send(1'b0, 4'h3); chk("init1", 32'({last_d, last_b}), 32'h030);
        send(1'b0, 4'h3); chk("init2", 32'({last_d, last_b}), 32'h030);
        send(1'b0, 4'h3); chk("init3", 32'({last_d, last_b}), 32'h030);
        chk("mode4_before", 32'(mode4), 32'h0);
        send(1'b0, 4'h2); chk("init4", 32'({last_d, last_b}), 32'h020);
        chk("mode4_after", 32'(mode4), 32'h1);
        chk("init_count", 32'(n_bytes), 32'd4);
        send(1'b0, 4'h2); send(1'b0, 4'h8);
        chk("funcset_28", 32'({last_d, last_b}), 32'h028);

        // Data 'A' and exact latency from the second enable fall.
        send(1'b1, 4'h4); send(1'b1, 4'h1);
        chk("data_41", 32'({last_d, last_b}), 32'h141);
        chk("data_latency", 32'(last_cyc - last_fall), 32'(SYNC + 2));

        // Short pulse rejected, then a clean CLEAR command.
        nb = n_bytes; ns = n_short;
        pulse(1'b0, 1'b0, 4'h5, MINE - 1); step(3);
        chk("short_pulse", 32'(n_short - ns), 32'd1);
        chk("short_nobyte", 32'(n_bytes - nb), 32'd0);
        send(1'b0, 4'h0); send(1'b0, 4'h1);
        chk("clear_cmd", 32'({last_d, last_b}), 32'({1'b0, LCD_CMD_CLEAR}));

        // RS glitch between nibbles.
        nr = n_rs;
        send(1'b1, 4'h4); send(1'b0, 4'h1);
        chk("rs_err", 32'(n_rs - nr), 32'd1);
        send(1'b0, 4'h6);
        chk("rs_recover_16", 32'({last_d, last_b}), 32'h016);

        // Timeout after a lone high nibble.
        nb = n_bytes; nt = n_to;
        send(1'b0, 4'h7);
        step(TO + 20);
        chk("timeout_once", 32'(n_to - nt), 32'd1);
        chk("timeout_nobyte", 32'(n_bytes - nb), 32'd0);
        send(1'b0, 4'h0); send(1'b0, 4'hC);
        chk("after_to_0c", 32'({last_d, last_b}), 32'h00C);

        // Read cycles leave no trace.
        nb = n_bytes; ns = n_short; nr = n_rs; nt = n_to;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1, 4'(i + 9), MINE + 3);
            step(2);
        end
        chk("rw_quiet", 32'((n_bytes - nb) + (n_short - ns) + (n_rs - nr) + (n_to - nt)), 32'd0);
        send(1'b0, 4'h0); send(1'b0, 4'h6);
        chk("entry_cmd", 32'({last_d, last_b}), 32'({1'b0, LCD_CMD_ENTRY}));

        // Reset between nibbles drops back to 8-bit mode.
        send(1'b0, 4'h0);
        rst = 1'b1;
        #1;
        chk("midrst_outs", 32'({byte_out, byte_valid, mode4}), 32'h0);
        do_reset();
        chk("midrst_mode4", 32'(mode4), 32'h0);
        send(1'b0, 4'h8);
        chk("post_rst_8bit", 32'({last_d, last_b}), 32'h080);

        // Randomized traffic against the model.
        send(1'b0, 4'h3); send(1'b0, 4'h3); send(1'b0, 4'h3); send(1'b0, 4'h2);
        for (int i = 0; i < 400; i++) begin
            logic       rs_r, rw_r;
            logic [3:0] nib_r;
            int         w_r;
            rs_r  = ($urandom_range(0, 4) == 0) ? ~lcd_rs : lcd_rs;
            rw_r  = ($urandom_range(0, 9) == 0);
            nib_r = 4'($urandom_range(0, 15));
            w_r   = MINE - 2 + $urandom_range(0, 7);
            pulse(rs_r, rw_r, nib_r, w_r);
            step($urandom_range(1, 6));
        end
        step(20);
        chk("events_drained", 32'(evq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
